// File: rtl/blink_detector_if.sv
// rtl/blink_detector_if.sv - signal bundle between a blink source and the blink detector
//
// Purpose: carries the monitored on/off line towards the detector and the
// debounced level plus interval measurements back from it.
// Members:
//   sig_in     : asynchronous monitored on/off line
//   level      : debounced level of sig_in
//   on_ms      : last measured high duration, whole ms
//   off_ms     : last measured low duration, whole ms
//   meas_valid : one-cycle strobe, on_ms/off_ms updated this cycle
//   timeout    : a measurement was abandoned; cleared by the next accepted rise
// Modports:
//   master : drives sig_in, observes the results (source / bench side)
//   slave  : samples sig_in, drives the results (detector side)
interface blink_detector_if #(
    parameter int CNT_W = 16
);
    logic             sig_in;
    logic             level;
    logic [CNT_W-1:0] on_ms;
    logic [CNT_W-1:0] off_ms;
    logic             meas_valid;
    logic             timeout;

    modport master (
        output sig_in,
        input  level,
        input  on_ms,
        input  off_ms,
        input  meas_valid,
        input  timeout
    );

    modport slave (
        input  sig_in,
        output level,
        output on_ms,
        output off_ms,
        output meas_valid,
        output timeout
    );
endinterface

// File: rtl/blink_detector.sv
// rtl/blink_detector.sv - synchronise, debounce and time an on/off blink signal in ms
//
// Purpose: receive-side counterpart of the LED flasher. sig_in is synchronised,
// debounced, and each high and low interval is measured in whole milliseconds.
// Every completed high/low pair is reported with a one-cycle strobe; a line that
// stops toggling for TIMEOUT_MS abandons the measurement and raises timeout.
// Ports:
//   clk   : system clock, CLK_RATE Hz
//   rst_n : asynchronous active-low reset
//   bus   : blink_detector_if.slave (sig_in in; level, on_ms, off_ms,
//           meas_valid, timeout out)
module blink_detector #(
    parameter int CLK_RATE        = 100000000,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int TIMEOUT_MS      = 5000,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    blink_detector_if.slave  bus
);
    localparam int PRESC_MAX = CLK_RATE / 1000 - 1;
    localparam int PRESC_W   = (PRESC_MAX > 0) ? $clog2(PRESC_MAX + 1) : 1;
    localparam int DB_W      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [PRESC_W-1:0] PRESC_TERM = PRESC_W'(PRESC_MAX);
    localparam logic [DB_W-1:0]    DB_TERM    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX    = '1;

    // A timeout larger than the saturated counter value can never be reached.
    localparam bit                 TMO_EN  = (64'(TIMEOUT_MS) <= ((64'd1 << CNT_W) - 64'd1));
    localparam logic [CNT_W-1:0]   TMO_PRE = CNT_W'(TIMEOUT_MS - 1);

    typedef enum logic [1:0] {
        ST_ACQUIRE = 2'd0,
        ST_HIGH    = 2'd1,
        ST_LOW     = 2'd2
    } state_e;

    logic [SYNC_STAGES-1:0] sync_chain_q, sync_chain_d;
    logic                   level_q, level_d;
    logic                   level_prev_q, level_prev_d;
    logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
    logic [PRESC_W-1:0]     presc_q, presc_d;
    logic [CNT_W-1:0]       ms_cnt_q, ms_cnt_d;
    logic [CNT_W-1:0]       pend_on_q, pend_on_d;
    logic [CNT_W-1:0]       on_ms_q, on_ms_d;
    logic [CNT_W-1:0]       off_ms_q, off_ms_d;
    logic                   meas_valid_q, meas_valid_d;
    logic                   timeout_q, timeout_d;
    state_e                 state_q, state_d;

    logic sync_q;
    logic rise, fall, edge_any;
    logic tick;
    logic tmo_hit;

    assign sync_q = sync_chain_q[SYNC_STAGES-1];

    // Edge pulses are valid for the single cycle after level changes.
    assign rise     = level_q & ~level_prev_q;
    assign fall     = ~level_q & level_prev_q;
    assign edge_any = rise | fall;
    assign tick     = (presc_q == PRESC_TERM);

    // Only the tick that would carry ms_cnt onto TIMEOUT_MS counts; an edge
    // in the same cycle wins and restarts the interval instead.
    assign tmo_hit = TMO_EN && tick && !edge_any && (ms_cnt_q == TMO_PRE);

    // Synchroniser, debounce and ms timebase.
    always_comb begin
        sync_chain_d = {sync_chain_q[SYNC_STAGES-2:0], bus.sig_in};

        level_d  = level_q;
        db_cnt_d = '0;
        if (sync_q != level_q) begin
            if (db_cnt_q == DB_TERM) begin
                level_d = sync_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
        level_prev_d = level_q;

        // Edge beats tick: the interval restarts and the pending tick is lost.
        presc_d  = presc_q + 1'b1;
        ms_cnt_d = ms_cnt_q;
        if (edge_any) begin
            presc_d  = '0;
            ms_cnt_d = '0;
        end else if (tick) begin
            presc_d = '0;
            if (ms_cnt_q != CNT_MAX) begin
                ms_cnt_d = ms_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_chain_q <= '0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            db_cnt_q     <= '0;
            presc_q      <= '0;
            ms_cnt_q     <= '0;
            pend_on_q    <= '0;
            on_ms_q      <= '0;
            off_ms_q     <= '0;
            meas_valid_q <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            sync_chain_q <= sync_chain_d;
            level_q      <= level_d;
            level_prev_q <= level_prev_d;
            db_cnt_q     <= db_cnt_d;
            presc_q      <= presc_d;
            ms_cnt_q     <= ms_cnt_d;
            pend_on_q    <= pend_on_d;
            on_ms_q      <= on_ms_d;
            off_ms_q     <= off_ms_d;
            meas_valid_q <= meas_valid_d;
            timeout_q    <= timeout_d;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ACQUIRE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACQUIRE: begin
                if (rise) state_d = ST_HIGH;
            end
            ST_HIGH: begin
                if (fall)         state_d = ST_LOW;
                else if (tmo_hit) state_d = ST_ACQUIRE;
            end
            ST_LOW: begin
                if (rise)         state_d = ST_HIGH;
                else if (tmo_hit) state_d = ST_ACQUIRE;
            end
            default: state_d = ST_ACQUIRE;
        endcase
    end

    // FSM outputs. Reported durations hold through a timeout; only a full
    // high-then-low pair ending in a rise updates them.
    always_comb begin
        pend_on_d    = pend_on_q;
        on_ms_d      = on_ms_q;
        off_ms_d     = off_ms_q;
        meas_valid_d = 1'b0;
        timeout_d    = timeout_q;
        case (state_q)
            ST_ACQUIRE: begin
                if (rise) timeout_d = 1'b0;
            end
            ST_HIGH: begin
                if (fall)         pend_on_d = ms_cnt_q;
                else if (tmo_hit) timeout_d = 1'b1;
            end
            ST_LOW: begin
                if (rise) begin
                    on_ms_d      = pend_on_q;
                    off_ms_d     = ms_cnt_q;
                    meas_valid_d = 1'b1;
                end else if (tmo_hit) begin
                    timeout_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.level      = level_q;
    assign bus.on_ms      = on_ms_q;
    assign bus.off_ms     = off_ms_q;
    assign bus.meas_valid = meas_valid_q;
    assign bus.timeout    = timeout_q;
endmodule

// File: tb/tb_blink_detector.sv
// tb/tb_blink_detector.sv - self-checking bench for blink_detector
module tb_blink_detector;
    localparam int MS_CYC = 1000;
    localparam int DEB    = 4;

    logic clk;
    logic rst0_n;
    logic rst1_n;

    int checks = 0;
    int errors = 0;

    blink_detector_if #(.CNT_W(8)) bus0 ();
    blink_detector_if #(.CNT_W(4)) bus1 ();

    blink_detector #(
        .CLK_RATE(1000000), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(DEB),
        .TIMEOUT_MS(20), .CNT_W(8)
    ) dut0 (
        .clk(clk), .rst_n(rst0_n), .bus(bus0)
    );

    blink_detector #(
        .CLK_RATE(1000000), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(DEB),
        .TIMEOUT_MS(100), .CNT_W(4)
    ) dut1 (
        .clk(clk), .rst_n(rst1_n), .bus(bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model, one slot per DUT. Durations are derived from the cycle
    // numbers of the edge pulses: whole ms elapsed since the previous edge.
    int   m_tlim [2] = '{20, 100};
    int   m_max  [2] = '{255, 15};
    logic [1:0] m_hist [2];
    int   m_run  [2];
    logic m_level[2];
    logic m_up   [2];
    logic m_dn   [2];
    int   m_t    [2];
    int   m_last [2];
    int   m_mode [2];   // 0 acquire, 1 high, 2 low
    int   m_pend [2];
    int   m_on   [2];
    int   m_off  [2];
    logic m_valid[2];
    logic m_tmo  [2];

    task automatic model_reset(input int k);
        m_hist[k] = 2'b00; m_run[k] = 0; m_level[k] = 1'b0;
        m_up[k] = 1'b0; m_dn[k] = 1'b0; m_t[k] = 0; m_last[k] = -1;
        m_mode[k] = 0; m_pend[k] = 0; m_on[k] = 0; m_off[k] = 0;
        m_valid[k] = 1'b0; m_tmo[k] = 1'b0;
    endtask

    task automatic model_step(input int k, input logic sin);
        int c;
        int el;
        c  = m_t[k];
        el = (c - m_last[k] - 1) / MS_CYC;
        if (el > m_max[k]) el = m_max[k];
        m_valid[k] = 1'b0;
        if (m_up[k] || m_dn[k]) begin
            if (m_mode[k] == 0 && m_up[k]) begin
                m_tmo[k] = 1'b0; m_mode[k] = 1;
            end else if (m_mode[k] == 1 && m_dn[k]) begin
                m_pend[k] = el; m_mode[k] = 2;
            end else if (m_mode[k] == 2 && m_up[k]) begin
                m_on[k] = m_pend[k]; m_off[k] = el; m_valid[k] = 1'b1; m_mode[k] = 1;
            end
            m_last[k] = c;
        end else if (m_mode[k] != 0 && m_tlim[k] <= m_max[k] &&
                     (c - m_last[k]) == m_tlim[k] * MS_CYC) begin
            m_tmo[k] = 1'b1; m_mode[k] = 0;
        end
        m_up[k] = 1'b0; m_dn[k] = 1'b0;
        if (m_hist[k][1] != m_level[k]) begin
            m_run[k]++;
            if (m_run[k] == DEB) begin
                m_level[k] = m_hist[k][1];
                m_run[k]   = 0;
                if (m_level[k]) m_up[k] = 1'b1;
                else            m_dn[k] = 1'b1;
            end
        end else begin
            m_run[k] = 0;
        end
        m_hist[k] = {m_hist[k][0], sin};
        m_t[k]++;
    endtask

    always @(posedge clk) begin
        if (!rst0_n) model_reset(0);
        else         model_step(0, bus0.sig_in);
        if (!rst1_n) model_reset(1);
        else         model_step(1, bus1.sig_in);
    end

    task automatic cmp(input int k, input logic rn, input logic lv, input int on,
                       input int off, input logic v, input logic t);
        logic e_lv, e_v, e_t;
        int   e_on, e_off;
        if (!rn) begin
            e_lv = 1'b0; e_on = 0; e_off = 0; e_v = 1'b0; e_t = 1'b0;
        end else begin
            e_lv = m_level[k]; e_on = m_on[k]; e_off = m_off[k];
            e_v = m_valid[k]; e_t = m_tmo[k];
        end
        checks++;
        if (lv !== e_lv || on != e_on || off != e_off || v !== e_v || t !== e_t) begin
            errors++;
            $display("FAIL cycle_dut%0d t=%0t: level=%0b on=%0d off=%0d valid=%0b timeout=%0b, expected level=%0b on=%0d off=%0d valid=%0b timeout=%0b",
                     k, $time, lv, on, off, v, t, e_lv, e_on, e_off, e_v, e_t);
        end
    endtask

    int strobes0 = 0, s_on0 = 0, s_off0 = 0;
    int strobes1 = 0, s_on1 = 0, s_off1 = 0;

    always @(negedge clk) begin
        cmp(0, rst0_n, bus0.level, int'(bus0.on_ms), int'(bus0.off_ms), bus0.meas_valid, bus0.timeout);
        cmp(1, rst1_n, bus1.level, int'(bus1.on_ms), int'(bus1.off_ms), bus1.meas_valid, bus1.timeout);
        if (bus0.meas_valid === 1'b1) begin
            strobes0++; s_on0 = int'(bus0.on_ms); s_off0 = int'(bus0.off_ms);
        end
        if (bus1.meas_valid === 1'b1) begin
            strobes1++; s_on1 = int'(bus1.on_ms); s_off1 = int'(bus1.off_ms);
        end
    end

    task automatic lit(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Called at posedge+1: set the line and hold it for n cycles.
    task automatic drv0(input logic v, input int n);
        bus0.sig_in = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drv1(input logic v, input int n);
        bus1.sig_in = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst0_n = 1'b0; rst1_n = 1'b0;
        bus0.sig_in = 1'b0; bus1.sig_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst0_n = 1'b1; rst1_n = 1'b1;
        @(negedge clk);
        lit("reset_level", bus0.level, 0);
        lit("reset_on_ms", int'(bus0.on_ms), 0);
        lit("reset_off_ms", int'(bus0.off_ms), 0);
        lit("reset_valid", bus0.meas_valid, 0);
        lit("reset_timeout", bus0.timeout, 0);
        @(posedge clk);
        #1;
        fork
            begin
                // Glitch filtering: 3-cycle pulse rejected, 4-cycle pulse accepted.
                drv0(1'b0, 10);
                drv0(1'b1, 3);
                drv0(1'b0, 30);
                lit("glitch3_level", bus0.level, 0);
                bus0.sig_in = 1'b1;
                repeat (4) @(posedge clk);
                #1;
                bus0.sig_in = 1'b0;
                @(posedge clk);
                @(negedge clk);
                lit("glitch4_level_c5", bus0.level, 0);
                @(posedge clk);
                @(negedge clk);
                lit("glitch4_level_c6", bus0.level, 1);
                @(posedge clk);
                #1;
                drv0(1'b0, 30);
                lit("glitch_level_back", bus0.level, 0);
                lit("glitch_strobes", strobes0, 0);

                // Square wave ~3 ms high / ~5 ms low from a fresh reset.
                rst0_n = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                rst0_n = 1'b1;
                drv0(1'b0, 100);
                drv0(1'b1, 3010);
                drv0(1'b0, 5010);
                lit("sq_no_strobe_first_pair", strobes0, 0);
                drv0(1'b1, 20);
                lit("sq_strobes_1", strobes0, 1);
                lit("sq_on_1", s_on0, 3);
                lit("sq_off_1", s_off0, 5);
                lit("model_sq_on", m_on[0], 3);
                drv0(1'b1, 2990);
                drv0(1'b0, 5010);
                drv0(1'b1, 20);
                lit("sq_strobes_2", strobes0, 2);
                lit("sq_on_2", s_on0, 3);
                lit("sq_off_2", s_off0, 5);
                drv0(1'b1, 1000);

                // Reset in the middle of a high phase.
                rst0_n = 1'b0;
                @(negedge clk);
                lit("midrst_level", bus0.level, 0);
                lit("midrst_on_ms", int'(bus0.on_ms), 0);
                lit("midrst_off_ms", int'(bus0.off_ms), 0);
                lit("midrst_valid", bus0.meas_valid, 0);
                lit("midrst_timeout", bus0.timeout, 0);
                @(posedge clk);
                #1;
                @(posedge clk);
                #1;
                rst0_n = 1'b1;
                drv0(1'b1, 3010);
                drv0(1'b0, 5010);
                lit("midrst_no_early_strobe", strobes0, 2);
                drv0(1'b1, 20);
                lit("midrst_strobes", strobes0, 3);
                lit("midrst_on", s_on0, 3);
                lit("midrst_off", s_off0, 5);

                // High exactly 7000 cycles, low exactly 3000: edge lands on the tick.
                drv0(1'b1, 6980);
                drv0(1'b0, 3000);
                bus0.sig_in = 1'b1;
                repeat (20) @(posedge clk);
                lit("coinc_strobes", strobes0, 4);
                lit("coinc_on", s_on0, 6);
                lit("coinc_off", s_off0, 2);
                lit("model_coinc_on", m_on[0], 6);

                // Stuck high: timeout 20 ms after the rise pulse.
                repeat (19986) @(posedge clk);
                @(negedge clk);
                lit("tmo_not_yet", bus0.timeout, 0);
                @(posedge clk);
                @(negedge clk);
                lit("tmo_set", bus0.timeout, 1);
                lit("tmo_no_strobe", strobes0, 4);
                @(posedge clk);
                #1;
                drv0(1'b1, 4992);
                drv0(1'b0, 3010);
                lit("tmo_fall_ignored", bus0.timeout, 1);
                drv0(1'b1, 20);
                lit("tmo_cleared_by_rise", bus0.timeout, 0);
                lit("tmo_strobes_after", strobes0, 4);
                lit("tmo_on_held", int'(bus0.on_ms), 6);
                drv0(1'b1, 100);
            end
            begin
                // Narrow counters: on-time saturates, unreachable timeout never fires.
                drv1(1'b0, 100);
                drv1(1'b1, 18010);
                drv1(1'b0, 2010);
                lit("sat_no_strobe_first", strobes1, 0);
                lit("sat_no_timeout", bus1.timeout, 0);
                drv1(1'b1, 20);
                lit("sat_strobes", strobes1, 1);
                lit("sat_on", s_on1, 15);
                lit("sat_off", s_off1, 2);
            end
        join
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
